// File: rtl/bird_motion_pkg.sv
// rtl/bird_motion_pkg.sv - shared bird physics constants and life-cycle state encoding
package bird_motion_pkg;

  localparam int Y_W      = 10;
  localparam int FRAC_W   = 2;
  localparam int V_W      = 8;
  localparam int SCREEN_H = 480;
  localparam int BIRD_H   = 24;
  localparam int Y_START  = 228;
  localparam int GRAVITY  = 1;
  localparam int FLAP_V   = 24;
  localparam int V_MAX    = 40;

  localparam int YF_W = Y_W + FRAC_W;

  // Positions are kept in quarter-pixel fixed point throughout.
  localparam logic [YF_W-1:0]       Y_RESET  = YF_W'(Y_START << FRAC_W);
  localparam logic [YF_W-1:0]       Y_GROUND = YF_W'((SCREEN_H - BIRD_H) << FRAC_W);
  localparam logic signed [V_W-1:0] VY_FLAP  = V_W'(-FLAP_V);
  localparam logic signed [V_W-1:0] VY_MAX   = V_W'(V_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } bird_state_t;

endpackage

// File: rtl/bird_motion_if.sv
// rtl/bird_motion_if.sv - game-control inputs and bird position/state outputs
interface bird_motion_if;
  import bird_motion_pkg::*;

  logic                  flap;
  logic                  frame_tick;
  logic                  hit;
  logic [Y_W-1:0]        bird_y;
  logic signed [V_W-1:0] bird_vy;
  logic                  playing;
  logic                  game_over;

  modport master (
    output flap, frame_tick, hit,
    input  bird_y, bird_vy, playing, game_over
  );

  modport slave (
    input  flap, frame_tick, hit,
    output bird_y, bird_vy, playing, game_over
  );

endinterface

// File: rtl/bird_integrator.sv
// rtl/bird_integrator.sv - one frame of vertical motion with ceiling/ground detection
module bird_integrator
  import bird_motion_pkg::*;
(
  input  logic [YF_W-1:0]       y,
  input  logic signed [V_W-1:0] vy,
  input  logic                  pend,
  output logic signed [V_W-1:0] vy_nxt,
  output logic [YF_W-1:0]       y_nxt,
  output logic                  ceil,
  output logic                  ground
);

  localparam int S_W = YF_W + 1;
  localparam logic signed [V_W:0]   VG_MAX   = (V_W+1)'(V_MAX);
  localparam logic signed [V_W:0]   VG_GRAV  = (V_W+1)'(GRAVITY);
  localparam logic signed [S_W-1:0] GROUND_S = $signed({1'b0, Y_GROUND});

  logic signed [V_W:0]   vy_grav;
  logic signed [S_W-1:0] y_sum;

  // One extra bit on both sums so neither gravity nor a negative step can wrap.
  always_comb begin
    vy_grav = {vy[V_W-1], vy} + VG_GRAV;
    if (pend)
      vy_nxt = VY_FLAP;
    else if (vy_grav > VG_MAX)
      vy_nxt = VY_MAX;
    else
      vy_nxt = vy_grav[V_W-1:0];
    y_sum  = $signed({1'b0, y}) + S_W'(vy_nxt);
    ceil   = y_sum[S_W-1];
    ground = !ceil && (y_sum >= GROUND_S);
    y_nxt  = y_sum[YF_W-1:0];
  end

endmodule

// File: rtl/bird_motion.sv
// rtl/bird_motion.sv - bird life-cycle FSM and registered vertical position/velocity
module bird_motion
  import bird_motion_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  bird_motion_if.slave  bus
);

  bird_state_t           state;
  logic [YF_W-1:0]       y;
  logic signed [V_W-1:0] vy;
  logic                  flap_pend;
  logic                  playing;
  logic                  game_over;

  logic signed [V_W-1:0] vy_nxt;
  logic [YF_W-1:0]       y_nxt;
  logic                  ceil;
  logic                  ground;

  // A flap arriving on the tick cycle itself is consumed by that tick.
  bird_integrator u_integrator (
    .y      (y),
    .vy     (vy),
    .pend   (flap_pend | bus.flap),
    .vy_nxt (vy_nxt),
    .y_nxt  (y_nxt),
    .ceil   (ceil),
    .ground (ground)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      y         <= Y_RESET;
      vy        <= '0;
      flap_pend <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flap) begin
            state     <= RUN;
            flap_pend <= 1'b1;
            playing   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.hit) begin
            state     <= DEAD;
            flap_pend <= 1'b0;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end else if (bus.frame_tick) begin
            flap_pend <= 1'b0;
            if (ceil) begin
              y  <= '0;
              vy <= '0;
            end else if (ground) begin
              y         <= Y_GROUND;
              vy        <= '0;
              state     <= DEAD;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              y  <= y_nxt;
              vy <= vy_nxt;
            end
          end else if (bus.flap) begin
            flap_pend <= 1'b1;
          end
        end
        DEAD: begin
          // Restart only returns to IDLE; a fresh flap is needed to play again.
          if (bus.flap) begin
            state     <= IDLE;
            y         <= Y_RESET;
            vy        <= '0;
            flap_pend <= 1'b0;
            game_over <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          y         <= Y_RESET;
          vy        <= '0;
          flap_pend <= 1'b0;
          playing   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bird_y    = y[YF_W-1:FRAC_W];
  assign bus.bird_vy   = vy;
  assign bus.playing   = playing;
  assign bus.game_over = game_over;

endmodule
